serial_regfile: RTL and testbench
=================================

SERIAL_REGFILE -- requirements
Module: serial_regfile

Interface
REQ-001 Parameter NUM_REGS, default 4, number of 8-bit registers, legal range 1..8.
REQ-002 Parameter RESET_VALUE, default 8'h00, value loaded into every register on reset.
REQ-003 Parameter STRICT_PAIR, default 1, 1 = high-nibble commit requires a pending low nibble, 0 = commit with whatever is in hold.
REQ-004 sck  input  1  bit clock; all state changes on the rising edge; one serial bit per edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 sdi  input  1  serial data, idle high, sampled on the sck rising edge.
REQ-007 clr_err  input  1  synchronous clear of the sticky error flags.
REQ-008 regs  output  NUM_REGS*8  flat register bus, register n at bits [8n+7:8n].
REQ-009 reg_update  output  NUM_REGS  one-cycle pulse per register on commit.
REQ-010 reg_change  output  1  toggles on every commit to any register.
REQ-011 hold_valid  output  1  a low nibble is pending.
REQ-012 err  output  3  sticky flags: [0] framing, [1] sequence, [2] address range.

Function
REQ-013 Frame format, 10 bits, LSB first: start 0, data[3:0], addr[3:0], stop 1.
REQ-014 addr[0]=0 selects a low-nibble frame; addr[0]=1 selects a high-nibble frame for register addr[3:1].
REQ-015 Receiver states: IDLE, RECV, RESYNC.
- IDLE: sdi=0 moves to RECV with bit_cnt cleared.
- RECV: shifts in 9 bits. The 9th bit is the stop bit, and the frame is evaluated on the edge that samples it.
- RECV with stop=1 returns to IDLE. The next edge may sample a new start bit, so back-to-back frames are supported.
- RECV with stop=0 sets err[0], discards the frame and moves to RESYNC.
- RESYNC: stays until sdi=1 is sampled, then moves to IDLE.
REQ-016 Low-nibble frame with a valid stop bit: hold <= data and hold_valid <= 1; no register changes. A new low-nibble frame overwrites hold.
REQ-017 High-nibble frame, addr[3:1] < NUM_REGS, and hold_valid=1 (or STRICT_PAIR=0):
- register <= {data, hold}
- hold_valid <= 0
- reg_update[addr[3:1]] pulses for exactly one cycle
- reg_change toggles
REQ-018 High-nibble frame with hold_valid=0 and STRICT_PAIR=1: no commit, err[1] set, hold_valid stays 0.
REQ-019 High-nibble frame with addr[3:1] >= NUM_REGS: no commit, err[2] set, hold_valid <= 0.
REQ-020 Latency: committed values are visible on regs, reg_update and reg_change in the cycle after the stop-bit edge.
REQ-021 At most one register commits per frame; reg_update is one-hot or zero.
REQ-022 Error flags are sticky.
- clr_err=1 clears them on the next edge.
- An error event on the same edge as clr_err leaves that flag set; set wins over clear.
REQ-023 A framing-error frame affects neither hold nor hold_valid.
REQ-024 Registers with index >= NUM_REGS do not exist; regs width is exactly NUM_REGS*8.

Reset
REQ-025 rst_n=0 immediately, without waiting for sck, sets:
- receiver state to IDLE and bit_cnt to 0
- every register to RESET_VALUE
- hold and hold_valid to 0
- reg_update, reg_change and err to 0
REQ-026 Reset asserted mid-frame discards the partial frame. After release, the receiver waits in IDLE for a fresh start bit.

Verification
REQ-027 Pair write, NUM_REGS=4:
- low frame addr=4'h4, data=4'h5, then high frame addr=4'h5, data=4'hA
- regs[23:16]=8'hA5, reg_update=4'b0100 for one cycle, reg_change toggles once, err=0
REQ-028 Back-to-back writes with no idle bits between frames:
- write 8'h3C to reg 0, then 8'hF0 to reg 3
- both commit, and reg_change returns to its initial value
REQ-029 Framing error:
- frame with stop=0, then sdi held 0 for 5 cycles, then 1
- err[0]=1, no commit; the next valid pair writes correctly
- clr_err then clears err
REQ-030 Sequence and range errors:
- high frame with no pending low nibble: err[1]=1 and regs unchanged
- pair to reg 6 with NUM_REGS=4: err[2]=1 and no reg_update
REQ-031 Async reset:
- rst_n pulsed low at bit 5 of a high frame, with no sck edge during the pulse
- all regs return to RESET_VALUE immediately; the aborted frame causes no commit
REQ-032 STRICT_PAIR=0: a high frame alone to reg 1 with hold=0 writes {data, 4'h0} and does not set err[1].

Source files
------------

// File: rtl/serial_regfile.sv
// Serial-loaded register file: 10-bit LSB-first frames carry nibbles that are
// paired (low then high) into 8-bit registers, with sticky error reporting.
module serial_regfile #(
  parameter int unsigned NUM_REGS    = 4,
  parameter logic [7:0]  RESET_VALUE = 8'h00,
  parameter bit          STRICT_PAIR = 1'b1
) (
  input  logic                  sck,
  input  logic                  rst_n,
  input  logic                  sdi,
  input  logic                  clr_err,
  output logic [NUM_REGS*8-1:0] regs,
  output logic [NUM_REGS-1:0]   reg_update,
  output logic                  reg_change,
  output logic                  hold_valid,
  output logic [2:0]            err
);

  localparam int unsigned RegW   = 8;
  localparam int unsigned BusW   = NUM_REGS * RegW;
  localparam int unsigned CntW   = 4;
  localparam int unsigned StopIx = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_RESYNC = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [RegW-1:0]   shift_q, shift_d;
  logic [BusW-1:0]   regs_q, regs_d;
  logic [NUM_REGS-1:0] upd_q, upd_d;
  logic              chg_q, chg_d;
  logic [3:0]        hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic [2:0]        err_q, err_d;

  logic       frame_ok, frame_bad, lo_wr, commit, seq_err, rng_err;
  logic [3:0] f_data, f_addr;
  logic [2:0] f_idx;
  logic       in_range, pair_ok;

  // Receiver state register
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // Receiver next state; data and address are shifted in, stop bit is not
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (!sdi) begin
          state_d   = ST_RECV;
          bit_cnt_d = '0;
        end
      end
      ST_RECV: begin
        if (bit_cnt_q == CntW'(StopIx)) begin
          state_d   = sdi ? ST_IDLE : ST_RESYNC;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
          shift_d   = {sdi, shift_q[RegW-1:1]};
        end
      end
      ST_RESYNC: begin
        if (sdi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame decode on the stop-bit edge
  always_comb begin
    f_data    = shift_q[3:0];
    f_addr    = shift_q[7:4];
    f_idx     = f_addr[3:1];
    in_range  = {1'b0, f_idx} < 4'(NUM_REGS);
    pair_ok   = hold_valid_q || !STRICT_PAIR;
    frame_ok  = (state_q == ST_RECV) && (bit_cnt_q == CntW'(StopIx)) && sdi;
    frame_bad = (state_q == ST_RECV) && (bit_cnt_q == CntW'(StopIx)) && !sdi;
    lo_wr     = frame_ok && !f_addr[0];
    commit    = frame_ok && f_addr[0] && in_range && pair_ok;
    seq_err   = frame_ok && f_addr[0] && in_range && !pair_ok;
    rng_err   = frame_ok && f_addr[0] && !in_range;
  end

  // Register file, hold nibble and error next state; set wins over clear
  always_comb begin
    regs_d       = regs_q;
    upd_d        = '0;
    chg_d        = chg_q ^ commit;
    hold_d       = lo_wr ? f_data : hold_q;
    hold_valid_d = hold_valid_q;
    err_d        = (clr_err ? 3'b000 : err_q) | {rng_err, seq_err, frame_bad};
    if (lo_wr)                hold_valid_d = 1'b1;
    else if (commit || rng_err) hold_valid_d = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (commit && (f_idx == 3'(i))) begin
        regs_d[i*RegW +: RegW] = {f_data, hold_q};
        upd_d[i]               = 1'b1;
      end
    end
  end

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      regs_q       <= {NUM_REGS{RESET_VALUE}};
      upd_q        <= '0;
      chg_q        <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      err_q        <= '0;
    end else begin
      regs_q       <= regs_d;
      upd_q        <= upd_d;
      chg_q        <= chg_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      err_q        <= err_d;
    end
  end

  assign regs       = regs_q;
  assign reg_update = upd_q;
  assign reg_change = chg_q;
  assign hold_valid = hold_valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_serial_regfile.sv
// Directed bench for serial_regfile: expected commits are queued as frames are
// sent and retired against reg_update/regs/reg_change when the DUT commits.
module tb_serial_regfile;

  logic        sck = 1'b0;
  logic        rst_n, sdi, sdi2, clr_err;
  logic [31:0] regs;
  logic [3:0]  reg_update;
  logic        reg_change, hold_valid;
  logic [2:0]  err;
  logic [15:0] regs2;
  logic [1:0]  reg_update2;
  logic        reg_change2, hold_valid2;
  logic [2:0]  err2;

  int total = 0;
  int bad   = 0;
  int sel   = 0;

  typedef struct {
    int         sel;
    int         idx;
    logic [7:0] val;
    logic       rc;
  } exp_t;
  exp_t       sb[$];
  logic [7:0] mreg[4];
  logic       mrc, mrc2;

  always #5 sck = ~sck;

  serial_regfile #(.NUM_REGS(4), .RESET_VALUE(8'h00), .STRICT_PAIR(1'b1)) dut (
    .sck(sck), .rst_n(rst_n), .sdi(sdi), .clr_err(clr_err),
    .regs(regs), .reg_update(reg_update), .reg_change(reg_change),
    .hold_valid(hold_valid), .err(err)
  );

  serial_regfile #(.NUM_REGS(2), .RESET_VALUE(8'hC3), .STRICT_PAIR(1'b0)) dut2 (
    .sck(sck), .rst_n(rst_n), .sdi(sdi2), .clr_err(clr_err),
    .regs(regs2), .reg_update(reg_update2), .reg_change(reg_change2),
    .hold_valid(hold_valid2), .err(err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one bit, let the next rising edge sample it, return 1 time unit later
  task automatic drive(input logic b);
    if (sel == 0) sdi = b;
    else          sdi2 = b;
    @(posedge sck);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] a, input logic [3:0] d,
                            input logic stop, input logic clr_on_stop);
    drive(1'b0);
    for (int i = 0; i < 4; i++) drive(d[i]);
    for (int i = 0; i < 4; i++) drive(a[i]);
    if (clr_on_stop) clr_err = 1'b1;
    drive(stop);
    clr_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1);
  endtask

  function automatic logic [31:0] model_regs();
    return {mreg[3], mreg[2], mreg[1], mreg[0]};
  endfunction

  task automatic push_commit(input int s, input int idx, input logic [7:0] val);
    exp_t e;
    e.sel = s;
    e.idx = idx;
    e.val = val;
    if (s == 0) begin
      mrc       = ~mrc;
      mreg[idx] = val;
      e.rc      = mrc;
    end else begin
      mrc2 = ~mrc2;
      e.rc = mrc2;
    end
    sb.push_back(e);
  endtask

  task automatic check_commit(input string tag);
    exp_t e;
    chk({tag, "_pending"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.sel == 0) begin
        chk({tag, "_upd"}, 32'(reg_update), 32'd1 << e.idx);
        chk({tag, "_reg"}, 32'(regs[e.idx*8 +: 8]), 32'(e.val));
        chk({tag, "_chg"}, 32'(reg_change), 32'(e.rc));
      end else begin
        chk({tag, "_upd"}, 32'(reg_update2), 32'd1 << e.idx);
        chk({tag, "_reg"}, 32'(regs2[e.idx*8 +: 8]), 32'(e.val));
        chk({tag, "_chg"}, 32'(reg_change2), 32'(e.rc));
      end
    end
  endtask

  task automatic pair_write(input int idx, input logic [7:0] val, input string tag);
    push_commit(sel, idx, val);
    send_frame({3'(idx), 1'b0}, val[3:0], 1'b1, 1'b0);
    send_frame({3'(idx), 1'b1}, val[7:4], 1'b1, 1'b0);
    check_commit(tag);
  endtask

  initial begin
    rst_n   = 1'b0;
    sdi     = 1'b1;
    sdi2    = 1'b1;
    clr_err = 1'b0;
    mrc     = 1'b0;
    mrc2    = 1'b0;
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
    repeat (3) @(posedge sck);
    #1;
    chk("rst_regs", regs, 32'h0);
    chk("rst_upd", 32'(reg_update), 32'h0);
    chk("rst_chg", 32'(reg_change), 32'h0);
    chk("rst_hv", 32'(hold_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_regs2", 32'(regs2), 32'h0000C3C3);
    rst_n = 1'b1;
    idle(2);

    // Single pair write to register 2
    push_commit(0, 2, 8'hA5);
    send_frame(4'h4, 4'h5, 1'b1, 1'b0);
    chk("pair_lo_hv", 32'(hold_valid), 32'h1);
    chk("pair_lo_upd", 32'(reg_update), 32'h0);
    chk("pair_lo_regs", regs, 32'h0);
    send_frame(4'h5, 4'hA, 1'b1, 1'b0);
    check_commit("pair");
    chk("pair_regs", regs, model_regs());
    chk("pair_hv", 32'(hold_valid), 32'h0);
    chk("pair_err", 32'(err), 32'h0);
    idle(1);
    chk("pair_pulse_end", 32'(reg_update), 32'h0);
    chk("pair_chg_hold", 32'(reg_change), 32'h1);

    // Back-to-back pairs with no idle bits
    pair_write(0, 8'h3C, "b2b0");
    pair_write(3, 8'hF0, "b2b3");
    idle(1);
    chk("b2b_chg", 32'(reg_change), 32'h1);
    chk("b2b_regs", regs, model_regs());

    // Framing error keeps pending hold; resync after a run of zeros
    send_frame(4'h2, 4'h9, 1'b1, 1'b0);
    send_frame(4'h0, 4'h3, 1'b0, 1'b0);
    chk("frm_err", 32'(err), 32'h1);
    chk("frm_hv", 32'(hold_valid), 32'h1);
    chk("frm_upd", 32'(reg_update), 32'h0);
    repeat (5) drive(1'b0);
    drive(1'b1);
    chk("frm_regs", regs, model_regs());
    push_commit(0, 1, 8'h49);
    send_frame(4'h3, 4'h4, 1'b1, 1'b0);
    check_commit("frm_after");
    pair_write(1, 8'h77, "frm_pair");
    chk("frm_err_sticky", 32'(err), 32'h1);
    clr_err = 1'b1;
    drive(1'b1);
    clr_err = 1'b0;
    chk("frm_clr", 32'(err), 32'h0);

    // Sequence error, then range error with clear on the same edge
    send_frame(4'h3, 4'h6, 1'b1, 1'b0);
    chk("seq_err", 32'(err), 32'h2);
    chk("seq_upd", 32'(reg_update), 32'h0);
    chk("seq_hv", 32'(hold_valid), 32'h0);
    chk("seq_regs", regs, model_regs());
    send_frame(4'hC, 4'h1, 1'b1, 1'b0);
    chk("rng_lo_hv", 32'(hold_valid), 32'h1);
    send_frame(4'hD, 4'h2, 1'b1, 1'b1);
    chk("rng_err_setwin", 32'(err), 32'h4);
    chk("rng_upd", 32'(reg_update), 32'h0);
    chk("rng_hv", 32'(hold_valid), 32'h0);
    chk("rng_regs", regs, model_regs());
    clr_err = 1'b1;
    drive(1'b1);
    clr_err = 1'b0;
    chk("rng_clr", 32'(err), 32'h0);

    // Asynchronous reset in the middle of a high frame
    send_frame(4'h6, 4'h1, 1'b1, 1'b0);
    drive(1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0);
    drive(1'b1);
    rst_n = 1'b0;
    #2;
    chk("arst_regs", regs, 32'h0);
    chk("arst_hv", 32'(hold_valid), 32'h0);
    chk("arst_chg", 32'(reg_change), 32'h0);
    chk("arst_upd", 32'(reg_update), 32'h0);
    chk("arst_regs2", 32'(regs2), 32'h0000C3C3);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
    mrc = 1'b0;
    idle(4);
    chk("arst_nocommit", 32'(reg_update), 32'h0);
    chk("arst_regs_after", regs, 32'h0);
    send_frame(4'h7, 4'h2, 1'b1, 1'b0);
    chk("arst_hold_gone", 32'(err), 32'h2);
    chk("arst_hold_regs", regs, 32'h0);
    pair_write(3, 8'h81, "arst_pair");
    chk("arst_pair_regs", regs, model_regs());

    // Unpaired high nibble accepted when pairing is not enforced
    sel = 1;
    push_commit(1, 1, 8'hB0);
    send_frame(4'h3, 4'hB, 1'b1, 1'b0);
    check_commit("loose");
    chk("loose_regs", 32'(regs2), 32'h0000B0C3);
    chk("loose_err", 32'(err2), 32'h0);
    chk("loose_hv", 32'(hold_valid2), 32'h0);
    idle(1);
    chk("loose_pulse_end", 32'(reg_update2), 32'h0);
    sel = 0;

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
